// File: rtl/regfile_access_ctrl_if.sv
// Bundle between the decode/execute/writeback stages, the register file and
// regfile_access_ctrl. The controller uses the slave modport, the surrounding pipeline the master.
interface regfile_access_ctrl_if #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
);
  logic            dec_valid;
  logic            dec_ready;
  logic [AW-1:0]   dec_sr1;
  logic [AW-1:0]   dec_sr2;
  logic            dec_use2;
  logic [AW-1:0]   dec_dr;
  logic            dec_wb;
  logic            flush;
  logic [AW-1:0]   rf_sr1Addr;
  logic [AW-1:0]   rf_sr2Addr;
  logic            rf_ldData;
  logic            rf_clrData;
  logic            ex_valid;
  logic            ex_ready;
  logic [AW-1:0]   ex_dr;
  logic            ex_wb;
  logic            wba_valid;
  logic            wba_ready;
  logic [AW-1:0]   wba_addr;
  logic [DW-1:0]   wba_data;
  logic            wbb_valid;
  logic            wbb_ready;
  logic [AW-1:0]   wbb_addr;
  logic [DW-1:0]   wbb_data;
  logic            rf_wr;
  logic [AW-1:0]   rf_drAddr;
  logic [DW-1:0]   rf_writeData;
  logic [NREG-1:0] busy;
  logic [15:0]     stall_cnt;

  modport slave (
    input  dec_valid, dec_sr1, dec_sr2, dec_use2, dec_dr, dec_wb, flush, ex_ready,
    input  wba_valid, wba_addr, wba_data, wbb_valid, wbb_addr, wbb_data,
    output dec_ready, rf_sr1Addr, rf_sr2Addr, rf_ldData, rf_clrData, ex_valid, ex_dr, ex_wb,
    output wba_ready, wbb_ready, rf_wr, rf_drAddr, rf_writeData, busy, stall_cnt
  );

  modport master (
    output dec_valid, dec_sr1, dec_sr2, dec_use2, dec_dr, dec_wb, flush, ex_ready,
    output wba_valid, wba_addr, wba_data, wbb_valid, wbb_addr, wbb_data,
    input  dec_ready, rf_sr1Addr, rf_sr2Addr, rf_ldData, rf_clrData, ex_valid, ex_dr, ex_wb,
    input  wba_ready, wbb_ready, rf_wr, rf_drAddr, rf_writeData, busy, stall_cnt
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Operand-fetch sequencer with busy-bit hazard scoreboard and round-robin write-port arbiter.
// Optional hazard stall counter enabled by defining RFAC_STALL_CNT_EN.
module regfile_access_ctrl #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   sr1Lat;
  logic [AW-1:0]   sr2Lat;
  logic [AW-1:0]   drLat;
  logic            use2Lat;
  logic            wbLat;
  logic [NREG-1:0] busyR;
  logic            rrB;

  logic            hazard;
  logic            grantA;
  logic            grantB;
  logic            wrEn;
  logic [AW-1:0]   wrAddr;
  logic [DW-1:0]   wrData;
  logic [NREG-1:0] clrMask;
  logic [NREG-1:0] setMask;
  logic [NREG-1:0] busyNext;

  // Hazard check against the registered scoreboard, so same-edge writebacks are never bypassed
  always_comb begin
    hazard = busyR[sr1Lat] | (use2Lat & busyR[sr2Lat]) | (wbLat & busyR[drLat]);
  end

  // Write-port arbitration: rrB names the side that wins when both request
  always_comb begin
    grantA = bus.wba_valid & (~bus.wbb_valid | ~rrB);
    grantB = bus.wbb_valid & (~bus.wba_valid | rrB);
    wrEn   = bus.wba_valid | bus.wbb_valid;
    if (grantA) begin
      wrAddr = bus.wba_addr;
      wrData = bus.wba_data;
    end else if (grantB) begin
      wrAddr = bus.wbb_addr;
      wrData = bus.wbb_data;
    end else begin
      wrAddr = {AW{1'b0}};
      wrData = {DW{1'b0}};
    end
  end

  // Scoreboard update: retiring writes and killed instructions clear, issue sets (set wins)
  always_comb begin
    clrMask = {NREG{1'b0}};
    setMask = {NREG{1'b0}};
    if (wrEn) begin
      clrMask = {{(NREG-1){1'b0}}, 1'b1} << wrAddr;
    end else begin
      clrMask = {NREG{1'b0}};
    end
    if (bus.flush && (state == HOLD) && wbLat) begin
      clrMask = clrMask | ({{(NREG-1){1'b0}}, 1'b1} << drLat);
    end else if (!bus.flush && (state == CHECK) && !hazard && wbLat) begin
      setMask = {{(NREG-1){1'b0}}, 1'b1} << drLat;
    end else begin
      setMask = {NREG{1'b0}};
    end
    busyNext = (busyR & ~clrMask) | setMask;
  end

  // Outputs are decoded from registered state; only arbiter and clear paths are combinational
  always_comb begin
    bus.dec_ready    = (state == IDLE) & ~bus.flush & ~rst;
    bus.rf_ldData    = (state == CHECK) & ~hazard & ~bus.flush & ~rst;
    bus.rf_clrData   = rst | bus.flush;
    bus.ex_valid     = (state == HOLD);
    bus.ex_dr        = drLat;
    bus.ex_wb        = wbLat;
    bus.rf_sr1Addr   = sr1Lat;
    bus.rf_sr2Addr   = sr2Lat;
    bus.wba_ready    = grantA;
    bus.wbb_ready    = grantB;
    bus.rf_wr        = wrEn;
    bus.rf_drAddr    = wrAddr;
    bus.rf_writeData = wrData;
    bus.busy         = busyR;
  end

  // Instruction sequencer, scoreboard and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr1Lat  <= {AW{1'b0}};
      sr2Lat  <= {AW{1'b0}};
      drLat   <= {AW{1'b0}};
      use2Lat <= 1'b0;
      wbLat   <= 1'b0;
      busyR   <= {NREG{1'b0}};
      rrB     <= 1'b0;
    end else begin
      busyR <= busyNext;
      if (bus.wba_valid && bus.wbb_valid) begin
        rrB <= grantA;
      end else begin
        rrB <= rrB;
      end
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.dec_valid) begin
              sr1Lat  <= bus.dec_sr1;
              sr2Lat  <= bus.dec_sr2;
              use2Lat <= bus.dec_use2;
              drLat   <= bus.dec_dr;
              wbLat   <= bus.dec_wb;
              state   <= CHECK;
            end else begin
              state <= IDLE;
            end
          end
          CHECK: begin
            if (!hazard) begin
              state <= HOLD;
            end else begin
              state <= CHECK;
            end
          end
          HOLD: begin
            if (bus.ex_ready) begin
              state <= IDLE;
            end else begin
              state <= HOLD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef RFAC_STALL_CNT_EN
  logic [15:0] stallCnt;

  // Saturating count of stalled CHECK cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= 16'd0;
    end else if ((state == CHECK) && hazard && !bus.flush && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end else begin
      stallCnt <= stallCnt;
    end
  end

  assign bus.stall_cnt = stallCnt;
`else
  assign bus.stall_cnt = 16'd0;
`endif

endmodule
